wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-stage producer for the integer register file's single write port.
- Drives rd_addr_wb, rd_data_wb and rd_en_wb, one register stage after selection.
- Merges two result sources: the execute pipe (fixed latency, cannot be back-pressured except via a stall) and load responses from the LSU (variable latency, valid/ready).
- Load responses wait in a small in-order queue and are protected from starvation.

Parameters:
- DW, 32, data width of results and write port.
- LQ_DEPTH, 2, load queue entries (≥1).
- STARVE_MAX, 4, cycles a queued load may lose arbitration before exu_stall is forced (≥1).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- exu_valid  in  1  execute result present this cycle.
- exu_rd_addr  in  5  execute destination register.
- exu_data  in  DW  execute result.
- exu_stall  out  1  this cycle's exu result is not taken; upstream must hold it.
- lsu_rsp_valid  in  1  load response valid.
- lsu_rsp_ready  out  1  queue can accept (= not full).
- lsu_rd_addr  in  5  load destination register.
- lsu_data  in  DW  raw 32-bit load word.
- lsu_size  in  2  00 byte, 01 half, 10/11 word.
- lsu_unsigned  in  1  zero-extend (1) or sign-extend (0).
- lsu_byte_off  in  2  byte offset of access within word.
- rd_addr_wb  out  5  write address to register file.
- rd_data_wb  out  DW  write data.
- rd_en_wb  out  1  write enable.

Behaviour:
- Reset (async, rst_n=0):
  - rd_en_wb=0, rd_addr_wb=0, rd_data_wb=0.
  - Queue emptied; queued loads are discarded, including on reset mid-operation.
  - starve_cnt=0.
- Queue:
  - FIFO, LQ_DEPTH entries of {rd_addr, data, size, unsigned, off}.
  - lsu_rsp_ready = (count != LQ_DEPTH), combinational from state only.
  - Push on lsu_rsp_valid && lsu_rsp_ready.
  - No flow-through: a pushed entry is eligible the following cycle.
  - Push and pop in the same cycle leave count unchanged.
  - While full, ready=0 and a simultaneous pop does not admit a push that cycle.
- Arbitration, each cycle:
  - exu_stall = (starve_cnt == STARVE_MAX) && queue non-empty.
  - If exu_stall: pop head, select load, ignore exu_valid.
  - Else if exu_valid: select exu.
  - Else if queue non-empty: pop head, select load.
  - Else: nothing selected.
- Starvation counter:
  - Increments when the queue is non-empty, exu_valid=1, and no pop occurs.
  - Cleared on any pop or when the queue is empty.
  - Saturates at STARVE_MAX.
- Output stage:
  - Selected result is registered: outputs are valid in the cycle after selection.
  - rd_en_wb=1 only if a source was selected and its rd_addr != 0.
  - Selections to x0 are consumed (popped/accepted) with rd_en_wb=0.
  - When idle, rd_en_wb=0; rd_addr_wb and rd_data_wb hold their last values.
- Latency:
  - exu result to rd_en_wb: 1 cycle.
  - Load accept to rd_en_wb: ≥2 cycles.
- Ordering: loads are written strictly in acceptance order.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined: load data is aligned and extended at pop time.
  - Byte: lane = byte_off; bits [7:0] extended to DW.
  - Half: lane = byte_off[1] (upper/lower 16 bits); byte_off[0] ignored; extended per lsu_unsigned.
  - Word (size 10/11): raw data, byte_off ignored.
- Undefined: lsu_size, lsu_unsigned and lsu_byte_off are ignored and not stored; lsu_data is written raw (LSU delivers pre-aligned data).

Test Plan:
- Reset mid-traffic:
  - Stimulus: queue 2 loads, assert rst_n=0.
  - Response: rd_en_wb=0 immediately; lsu_rsp_ready=1 after release; no stale writes.
- exu only:
  - Stimulus: exu_valid with rd=5, data 0x1234 at cycle N.
  - Response: rd_en_wb=1, rd_addr_wb=5, rd_data_wb=0x1234 at N+1. Same with rd=0 gives rd_en_wb=0.
- Back-to-back loads, queue full:
  - Stimulus: LQ_DEPTH=2, exu_valid held high, 3 loads offered.
  - Response: lsu_rsp_ready=0 after 2 accepts; third accepted only after a pop; writes in order.
- Starvation:
  - Stimulus: 1 queued load, exu_valid high continuously, STARVE_MAX=4.
  - Response: exu_stall=1 in the 5th cycle; load written next cycle; stalled exu result written the cycle after.
- Extension (WB_LOAD_EXT_EN):
  - Byte load, data 0x80FF7F01, off=3, signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Half load, off=2, signed → 0xFFFF80FF.
- Simultaneous events:
  - Stimulus: exu_valid and a load pushed into an empty queue in the same cycle.
  - Response: exu written at N+1, load at N+2; no loss or duplication.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges execute results and queued load responses onto the single register-file write port.
// Latency: exu result -> rd_en_wb 1 cycle; load accept -> rd_en_wb >= 2 cycles (queue has no flow-through).
// Backpressure: loads via lsu_rsp_ready (= queue not full); exu only via exu_stall when a queued load has starved.
//
// Ports:
//   clk, rst_n                 clock (posedge) and asynchronous active-low reset
//   exu_valid/rd_addr/data     execute result, must be held by upstream while exu_stall=1
//   exu_stall                  the current exu result is not taken this cycle
//   lsu_rsp_valid/ready        load response handshake; ready is a pure function of queue state
//   lsu_rd_addr/data           load destination and raw 32-bit word
//   lsu_size/unsigned/byte_off load shape, used only when WB_LOAD_EXT_EN is defined
//   rd_addr_wb/data_wb/en_wb   registered write port to the integer register file
//
// Optional feature macro: WB_LOAD_EXT_EN
//   defined   -> loads are lane-aligned and sign/zero-extended when popped from the queue
//   undefined -> lsu_size/lsu_unsigned/lsu_byte_off are ignored and not stored; lsu_data is written raw

module wb_arbiter #(
    parameter int DW         = 32,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          exu_valid,
    input  logic [4:0]    exu_rd_addr,
    input  logic [DW-1:0] exu_data,
    output logic          exu_stall,

    input  logic          lsu_rsp_valid,
    output logic          lsu_rsp_ready,
    input  logic [4:0]    lsu_rd_addr,
    input  logic [DW-1:0] lsu_data,
    input  logic [1:0]    lsu_size,
    input  logic          lsu_unsigned,
    input  logic [1:0]    lsu_byte_off,

    output logic [4:0]    rd_addr_wb,
    output logic [DW-1:0] rd_data_wb,
    output logic          rd_en_wb
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(LQ_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(LQ_DEPTH - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Load queue entry. Shape fields only exist when extension is built in.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]    rd_addr;
        logic [DW-1:0] data;
`ifdef WB_LOAD_EXT_EN
        logic [1:0]    size;
        logic          uns;
        logic [1:0]    off;
`endif
    } lq_entry_t;

    lq_entry_t       lq_mem [LQ_DEPTH];
    lq_entry_t       push_entry;
    lq_entry_t       head_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;

    logic            q_empty;
    logic            push;
    logic            pop;

    logic            sel_vld;
    logic [4:0]      sel_addr;
    logic [DW-1:0]   sel_data;
    logic [DW-1:0]   load_result;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef WB_LOAD_EXT_EN
    // Align the addressed lane to bit 0 and extend to DW.
    function automatic logic [DW-1:0] align_load(input lq_entry_t e);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (e.off)
            2'd0:    b = e.data[7:0];
            2'd1:    b = e.data[15:8];
            2'd2:    b = e.data[23:16];
            default: b = e.data[31:24];
        endcase
        // Halfword lane comes from off[1] only; off[0] is a misaligned bit we ignore.
        h = e.off[1] ? e.data[31:16] : e.data[15:0];
        case (e.size)
            2'b00:   r = {{(DW-8){b[7] & ~e.uns}}, b};
            2'b01:   r = {{(DW-16){h[15] & ~e.uns}}, h};
            default: r = e.data;
        endcase
        return r;
    endfunction
`else
    function automatic logic [DW-1:0] align_load(input lq_entry_t e);
        return e.data;
    endfunction

    // Shape inputs are deliberately dropped in this build.
    logic unused_shape;
    assign unused_shape = ^{lsu_size, lsu_unsigned, lsu_byte_off};
`endif

    // ------------------------------------------------------------------
    // Queue status and handshake
    // ------------------------------------------------------------------
    assign q_empty       = (count == '0);
    // Ready depends only on registered count: a same-cycle pop never frees a slot for a push.
    assign lsu_rsp_ready = (count != FULL_CNT);
    assign push          = lsu_rsp_valid && lsu_rsp_ready;

    always_comb begin
        push_entry         = '0;
        push_entry.rd_addr = lsu_rd_addr;
        push_entry.data    = lsu_data;
`ifdef WB_LOAD_EXT_EN
        push_entry.size    = lsu_size;
        push_entry.uns     = lsu_unsigned;
        push_entry.off     = lsu_byte_off;
`endif
    end

    assign head_entry  = lq_mem[rd_ptr];
    assign load_result = align_load(head_entry);

    // ------------------------------------------------------------------
    // Arbitration: starving load > exu > queued load
    // ------------------------------------------------------------------
    assign exu_stall = (starve_cnt == STARVE_LIM) && !q_empty;

    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        pop      = 1'b0;
        if (exu_stall) begin
            pop      = 1'b1;
            sel_vld  = 1'b1;
            sel_addr = head_entry.rd_addr;
            sel_data = load_result;
        end else if (exu_valid) begin
            sel_vld  = 1'b1;
            sel_addr = exu_rd_addr;
            sel_data = exu_data;
        end else if (!q_empty) begin
            pop      = 1'b1;
            sel_vld  = 1'b1;
            sel_addr = head_entry.rd_addr;
            sel_data = load_result;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage: no reset needed, pointers/count define validity.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            lq_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts cycles the head load loses to exu.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || q_empty) begin
            starve_cnt <= '0;
        end else if (exu_valid && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register. x0 selections are consumed but never write.
    // Address/data hold their last value while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_wb   <= 1'b0;
            rd_addr_wb <= '0;
            rd_data_wb <= '0;
        end else if (sel_vld) begin
            rd_en_wb   <= (sel_addr != 5'd0);
            rd_addr_wb <= sel_addr;
            rd_data_wb <= sel_data;
        end else begin
            rd_en_wb   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: model predicts write port one cycle after each selection.
// Backpressure: exu inputs are held while exu_stall is seen; loads are offered freely.

module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_valid = 1'b0;
    logic [4:0]  exu_rd_addr = '0;
    logic [31:0] exu_data = '0;
    logic        exu_stall;
    logic        lsu_rsp_valid = 1'b0;
    logic        lsu_rsp_ready;
    logic [4:0]  lsu_rd_addr = '0;
    logic [31:0] lsu_data = '0;
    logic [1:0]  lsu_size = '0;
    logic        lsu_unsigned = 1'b0;
    logic [1:0]  lsu_byte_off = '0;
    logic [4:0]  rd_addr_wb;
    logic [31:0] rd_data_wb;
    logic        rd_en_wb;

    wb_arbiter #(.DW(32), .LQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exu_valid     (exu_valid),
        .exu_rd_addr   (exu_rd_addr),
        .exu_data      (exu_data),
        .exu_stall     (exu_stall),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rd_addr   (lsu_rd_addr),
        .lsu_data      (lsu_data),
        .lsu_size      (lsu_size),
        .lsu_unsigned  (lsu_unsigned),
        .lsu_byte_off  (lsu_byte_off),
        .rd_addr_wb    (rd_addr_wb),
        .rd_data_wb    (rd_data_wb),
        .rd_en_wb      (rd_en_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        u;
        logic [1:0]  off;
    } ld_t;

    // Reference model state
    ld_t         mq[$];
    int          m_starve;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        obs_stall;
    logic        obs_ready;
    int          wr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input ld_t e);
        logic [31:0] v;
`ifdef WB_LOAD_EXT_EN
        if (e.sz == 2'b00) begin
            v = (e.d >> (8 * e.off)) & 32'hFF;
            if (!e.u && v > 32'd127) v = v | 32'hFFFF_FF00;
        end else if (e.sz == 2'b01) begin
            v = e.off[1] ? (e.d >> 16) : (e.d & 32'hFFFF);
            if (!e.u && v > 32'd32767) v = v | 32'hFFFF_0000;
        end else begin
            v = e.d;
        end
`else
        v = e.d;
`endif
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_starve = 0;
        m_en     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, step model, check write port.
    // Entered and left just after a negedge.
    task automatic do_cycle(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                            input logic lv, input logic [4:0] la, input logic [31:0] ld,
                            input logic [1:0] lsz, input logic lu, input logic [1:0] lo);
        logic exp_ready, exp_stall, was_empty, popped, sel;
        logic [4:0]  sa;
        logic [31:0] sd;
        ld_t h, n;
        exu_valid     = ev;
        exu_rd_addr   = ea;
        exu_data      = ed;
        lsu_rsp_valid = lv;
        lsu_rd_addr   = la;
        lsu_data      = ld;
        lsu_size      = lsz;
        lsu_unsigned  = lu;
        lsu_byte_off  = lo;
        #1;
        exp_ready = (mq.size() != DEPTH);
        exp_stall = (m_starve == SMAX) && (mq.size() > 0);
        chk("lsu_rsp_ready", 32'(lsu_rsp_ready), 32'(exp_ready));
        chk("exu_stall", 32'(exu_stall), 32'(exp_stall));
        obs_stall = exu_stall;
        obs_ready = lsu_rsp_ready;

        was_empty = (mq.size() == 0);
        popped = 1'b0;
        sel    = 1'b0;
        sa     = '0;
        sd     = '0;
        if (exp_stall || (!ev && !was_empty)) begin
            h = mq.pop_front();
            popped = 1'b1;
            sel = 1'b1;
            sa  = h.a;
            sd  = ext_model(h);
        end else if (ev) begin
            sel = 1'b1;
            sa  = ea;
            sd  = ed;
        end
        if (lv && exp_ready) begin
            n.a = la; n.d = ld; n.sz = lsz; n.u = lu; n.off = lo;
            mq.push_back(n);
        end
        if (popped || was_empty) m_starve = 0;
        else if (ev && m_starve < SMAX) m_starve++;
        if (sel) begin
            m_en   = (sa != 5'd0);
            m_addr = sa;
            m_data = sd;
        end else begin
            m_en = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("rd_en_wb", 32'(rd_en_wb), 32'(m_en));
        if (m_en) begin
            chk("rd_addr_wb", 32'(rd_addr_wb), 32'(m_addr));
            chk("rd_data_wb", rd_data_wb, m_data);
        end
        if (rd_en_wb) wr_log.push_back(int'(rd_addr_wb));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid low-phase, released on a negedge.
    task automatic apply_reset();
        exu_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_en", 32'(rd_en_wb), 32'd0);
        chk("rst_addr", 32'(rd_addr_wb), 32'd0);
        chk("rst_data", rd_data_wb, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(lsu_rsp_ready), 32'd1);
        chk("rst_stall", 32'(exu_stall), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, first_stall, nld;
        int lds[$];
        logic [31:0] exd;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;

        model_reset();
        @(negedge clk);
        apply_reset();

        // exu only: rd=5 then rd=x0
        do_cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
        chk("exu_en", 32'(rd_en_wb), 32'd1);
        chk("exu_addr", 32'(rd_addr_wb), 32'd5);
        chk("exu_data", rd_data_wb, 32'h1234);
        do_cycle(1, 0, 32'hBEEF, 0, 0, 0, 0, 0, 0);
        chk("exu_x0_en", 32'(rd_en_wb), 32'd0);
        idle(1);

        // Simultaneous exu and load into empty queue
        do_cycle(1, 3, 32'hAAAA_0001, 1, 9, 32'h5555_0002, 2'b10, 0, 0);
        chk("sim_exu_addr", 32'(rd_addr_wb), 32'd3);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sim_ld_en", 32'(rd_en_wb), 32'd1);
        chk("sim_ld_addr", 32'(rd_addr_wb), 32'd9);
        chk("sim_ld_data", rd_data_wb, 32'h5555_0002);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sim_no_dup", 32'(rd_en_wb), 32'd0);

        // Queue full with exu held busy, three loads offered
        wr_log.delete();
        acc = 0;
        exd = 32'h100;
        obs_stall = 1'b0;
        for (int c = 0; c < 40 && acc < 3; c++) begin
            if (!obs_stall) exd = 32'h100 + 32'(c);
            do_cycle(1, 20, exd, 1, 5'(11 + acc), 32'h200 + 32'(acc), 2'b10, 0, 0);
            if (acc == 2 && c == 2) chk("full_ready", 32'(obs_ready), 32'd0);
            if (obs_ready) acc++;
        end
        chk("full_accepts", 32'(acc), 32'd3);
        idle(6);
        lds.delete();
        foreach (wr_log[i]) if (wr_log[i] >= 11 && wr_log[i] <= 13) lds.push_back(wr_log[i]);
        nld = lds.size();
        chk("full_nloads", 32'(nld), 32'd3);
        for (int i = 0; i < 3; i++) if (i < nld) chk("full_order", 32'(lds[i]), 32'(11 + i));

        // Starvation: one queued load, exu busy every cycle
        do_cycle(1, 21, 32'h300, 1, 14, 32'h77, 2'b10, 0, 0);
        first_stall = 0;
        exd = 32'h300;
        obs_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (!obs_stall) exd = 32'h300 + 32'(k);
            do_cycle(1, 21, exd, 0, 0, 0, 0, 0, 0);
            if (obs_stall && first_stall == 0) first_stall = k;
        end
        chk("starve_cycle", 32'(first_stall), 32'd5);
        chk("starve_ld_en", 32'(rd_en_wb), 32'd1);
        chk("starve_ld_addr", 32'(rd_addr_wb), 32'd14);
        do_cycle(1, 21, exd, 0, 0, 0, 0, 0, 0);
        chk("starve_exu_addr", 32'(rd_addr_wb), 32'd21);
        chk("starve_exu_data", rd_data_wb, 32'h305);
        idle(2);

`ifdef WB_LOAD_EXT_EN
        do_cycle(0, 0, 0, 1, 6, 32'h80FF_7F01, 2'b00, 0, 2'd3);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ext_byte_s", rd_data_wb, 32'hFFFF_FF80);
        do_cycle(0, 0, 0, 1, 6, 32'h80FF_7F01, 2'b00, 1, 2'd3);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ext_byte_u", rd_data_wb, 32'h0000_0080);
        do_cycle(0, 0, 0, 1, 6, 32'h80FF_7F01, 2'b01, 0, 2'd2);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ext_half_s", rd_data_wb, 32'hFFFF_80FF);
        idle(1);
`endif

        // Reset with loads queued: nothing stale may be written
        do_cycle(1, 22, 32'h400, 1, 15, 32'h401, 2'b10, 0, 0);
        do_cycle(1, 22, 32'h402, 1, 16, 32'h403, 2'b10, 0, 0);
        apply_reset();
        wr_log.delete();
        idle(5);
        chk("rst_no_stale", 32'(wr_log.size()), 32'd0);

        // Random traffic
        ev = 1'b0; ea = '0; ed = '0;
        obs_stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!obs_stall) begin
                ev = ($urandom % 4) != 0;
                ea = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                ed = $urandom;
            end
            do_cycle(ev, ea, ed,
                     ($urandom % 2) == 0,
                     (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                     $urandom, 2'($urandom), 1'($urandom), 2'($urandom));
            if (($urandom % 700) == 0) begin
                apply_reset();
                obs_stall = 1'b0;
            end
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
